// File: rtl/start_debounce_trigger_if.sv
// Interface between the push-button front end and the counting FSM.
// master: the trigger block. slave: the environment that drives the button and busy.
interface start_debounce_trigger_if;
    localparam int unsigned STAT_W = 8;

    logic              btn_in;
    logic              busy_in;
    logic              start_req;
    logic              btn_level;
    logic [STAT_W-1:0] press_cnt;
    logic [STAT_W-1:0] drop_cnt;
    logic              timeout_p;

    modport master (
        input  btn_in,
        input  busy_in,
        output start_req,
        output btn_level,
        output press_cnt,
        output drop_cnt,
        output timeout_p
    );

    modport slave (
        output btn_in,
        output busy_in,
        input  start_req,
        input  btn_level,
        input  press_cnt,
        input  drop_cnt,
        input  timeout_p
    );
endinterface

// File: rtl/start_debounce_trigger.sv
// Synchronises and debounces a push-button, turns each clean press into a held start request.
// Optional request timeout is enabled by defining START_REQ_TIMEOUT_EN.
module start_debounce_trigger #(
    parameter logic [23:0] DEBOUNCE_CYCLES = 24'd10_000_000,
    parameter logic [7:0]  REQ_TIMEOUT     = 8'd16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    start_debounce_trigger_if.master  bus
);
    localparam int unsigned CNT_W  = 24;
    localparam int unsigned STAT_W = 8;
    localparam logic [CNT_W-1:0]  DB_LAST  = DEBOUNCE_CYCLES - CNT_W'(1);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    logic              sync_q1;
    logic              btn_s;
    logic              stable;
    logic              stable_q;
    logic              press_q;
    logic [CNT_W-1:0]  db_cnt;
    state_t            state;
    logic              start_req_q;
    logic [STAT_W-1:0] press_cnt_q;
    logic [STAT_W-1:0] drop_cnt_q;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            btn_s   <= 1'b0;
        end else begin
            sync_q1 <= bus.btn_in;
            btn_s   <= sync_q1;
        end
    end

    // Stable level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable <= 1'b0;
            db_cnt <= '0;
        end else if (btn_s == stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            stable <= btn_s;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + CNT_W'(1);
        end
    end

    // Registered level copy doubles as the rising-edge reference.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            stable_q <= stable;
            press_q  <= stable & ~stable_q;
        end
    end

`ifdef START_REQ_TIMEOUT_EN
    localparam logic [STAT_W-1:0] TO_LAST = REQ_TIMEOUT - STAT_W'(1);

    logic [STAT_W-1:0] req_timer;
    logic              timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^REQ_TIMEOUT;
`endif

    // Request handshake: IDLE -> REQ on press, REQ -> WAIT_DONE on busy, back on !busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            start_req_q <= 1'b0;
            press_cnt_q <= '0;
            drop_cnt_q  <= '0;
`ifdef START_REQ_TIMEOUT_EN
            req_timer   <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
`ifdef START_REQ_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (press_q) begin
                        state       <= REQ;
                        start_req_q <= 1'b1;
                        press_cnt_q <= press_cnt_q + STAT_W'(1);
`ifdef START_REQ_TIMEOUT_EN
                        req_timer   <= '0;
`endif
                    end
                end
                REQ: begin
                    if (bus.busy_in) begin
                        state       <= WAIT_DONE;
                        start_req_q <= 1'b0;
                    end
`ifdef START_REQ_TIMEOUT_EN
                    else if (req_timer == TO_LAST) begin
                        state       <= IDLE;
                        start_req_q <= 1'b0;
                        timeout_q   <= 1'b1;
                    end else begin
                        req_timer <= req_timer + STAT_W'(1);
                    end
`endif
                end
                WAIT_DONE: begin
                    if (!bus.busy_in) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    start_req_q <= 1'b0;
                end
            endcase

            // Presses outside IDLE are not queued, only counted.
            if (press_q && (state != IDLE) && (drop_cnt_q != STAT_MAX)) begin
                drop_cnt_q <= drop_cnt_q + STAT_W'(1);
            end
        end
    end

    assign bus.start_req = start_req_q;
    assign bus.btn_level = stable_q;
    assign bus.press_cnt = press_cnt_q;
    assign bus.drop_cnt  = drop_cnt_q;
`ifdef START_REQ_TIMEOUT_EN
    assign bus.timeout_p = timeout_q;
`else
    assign bus.timeout_p = 1'b0;
`endif

endmodule

// File: tb/tb_start_debounce_trigger.sv
// Directed and randomized bench for start_debounce_trigger against a history-based reference model.
module tb_start_debounce_trigger;
    localparam int unsigned DB_N = 4;
    localparam int unsigned TO_N = 8;
`ifdef START_REQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    start_debounce_trigger_if bus ();

    start_debounce_trigger #(
        .DEBOUNCE_CYCLES (24'(DB_N)),
        .REQ_TIMEOUT     (8'(TO_N))
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: outputs as seen after each clock edge.
    bit m_s1, m_s2;
    bit s_hist[$];
    bit m_stable, m_level, m_press;
    int m_phase;       // 0 waiting for press, 1 requesting, 2 waiting for done
    int m_req_cycles;
    bit m_req, m_to;
    int m_pcnt, m_dcnt;

    task automatic model_edge(input bit b, input bit bz, input bit r);
        bit bs, old_stable, old_level, old_press, flip;
        if (!r) begin
            m_s1 = 0; m_s2 = 0; s_hist.delete();
            m_stable = 0; m_level = 0; m_press = 0;
            m_phase = 0; m_req_cycles = 0; m_req = 0; m_to = 0;
            m_pcnt = 0; m_dcnt = 0;
            return;
        end
        bs = m_s2; old_stable = m_stable; old_level = m_level; old_press = m_press;
        // Level flips when the last DB_N synchronised samples all disagree with it.
        s_hist.push_back(bs);
        if (s_hist.size() > int'(DB_N)) void'(s_hist.pop_front());
        flip = (s_hist.size() == int'(DB_N));
        foreach (s_hist[i]) if (s_hist[i] == old_stable) flip = 0;
        if (flip) begin
            m_stable = ~old_stable;
            s_hist.delete();
        end
        m_level = old_stable;
        m_press = old_stable & ~old_level;
        m_to = 0;
        if (m_phase != 0 && old_press) m_dcnt = (m_dcnt < 255) ? m_dcnt + 1 : 255;
        case (m_phase)
            0: if (old_press) begin
                   m_phase = 1; m_req = 1; m_pcnt = (m_pcnt + 1) % 256; m_req_cycles = 0;
               end
            1: begin
                   if (bz) begin
                       m_phase = 2; m_req = 0;
                   end else if (TO_EN) begin
                       m_req_cycles++;
                       if (m_req_cycles == int'(TO_N)) begin
                           m_phase = 0; m_req = 0; m_to = 1;
                       end
                   end
               end
            default: if (!bz) m_phase = 0;
        endcase
        m_s2 = m_s1;
        m_s1 = b;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic step(input bit b, input bit bz, input bit r);
        bus.btn_in  = b;
        bus.busy_in = bz;
        rst_n       = r;
        @(posedge clk);
        model_edge(b, bz, r);
        #1;
        chk("start_req", 32'(bus.start_req), 32'(m_req));
        chk("btn_level", 32'(bus.btn_level), 32'(m_level));
        chk("press_cnt", 32'(bus.press_cnt), 32'(m_pcnt));
        chk("drop_cnt",  32'(bus.drop_cnt),  32'(m_dcnt));
        chk("timeout_p", 32'(bus.timeout_p), 32'(m_to));
    endtask

    task automatic steps(input int n, input bit b, input bit bz);
        for (int i = 0; i < n; i++) step(b, bz, 1'b1);
    endtask

    // Holds the button until start_req rises (bounded); returns whether it rose.
    task automatic press_until_req(output bit seen);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1'b1, 1'b0, 1'b1);
            if (bus.start_req === 1'b1) seen = 1;
        end
    endtask

    int lvl_at, req_at, hi, pulses;
    bit seen, rb, rbz, rr;
    int rlen;

    initial begin
        bus.btn_in  = 1'b0;
        bus.busy_in = 1'b0;
        rst_n       = 1'b0;

        // Reset and idle.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        steps(20, 1'b0, 1'b0);
        chk("idle_start_req", 32'(bus.start_req), 32'd0);
        chk("idle_press_cnt", 32'(bus.press_cnt), 32'd0);

        // Bounce: 3-cycle pulses never reach a 4-sample debounce.
        for (int i = 0; i < 5; i++) begin
            steps(3, 1'b1, 1'b0);
            steps(3, 1'b0, 1'b0);
        end
        chk("bounce_level", 32'(bus.btn_level), 32'd0);
        chk("bounce_press_cnt", 32'(bus.press_cnt), 32'd0);

        // Clean press: btn_s high after edge 2, level at 7, request at 8.
        lvl_at = 0; req_at = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0, 1'b1);
            if (bus.btn_level === 1'b1 && lvl_at == 0) lvl_at = i;
            if (bus.start_req === 1'b1 && req_at == 0) req_at = i;
        end
        chk("btn_level_latency", 32'(lvl_at), 32'd7);
        chk("start_req_latency", 32'(req_at), 32'd8);
        chk("press_cnt_first", 32'(bus.press_cnt), 32'd1);
        steps(10, 1'b0, 1'b0);
        steps(2, 1'b0, 1'b1);
        steps(2, 1'b0, 1'b0);

        // Handshake, press dropped while busy, then an accepted press.
        press_until_req(seen);
        chk("hs_req_seen", 32'(seen), 32'd1);
        steps(2, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("hs_req_fall", 32'(bus.start_req), 32'd0);
        steps(10, 1'b0, 1'b1);
        steps(10, 1'b1, 1'b1);
        steps(10, 1'b0, 1'b1);
        chk("hs_drop_cnt", 32'(bus.drop_cnt), 32'd1);
        chk("hs_press_cnt", 32'(bus.press_cnt), 32'd2);
        chk("hs_no_req", 32'(bus.start_req), 32'd0);
        steps(3, 1'b0, 1'b0);
        steps(10, 1'b1, 1'b0);
        chk("third_req", 32'(bus.start_req), 32'd1);
        chk("third_press_cnt", 32'(bus.press_cnt), 32'd3);

        // Reset while requesting with the button still held.
        step(1'b1, 1'b0, 1'b0);
        chk("rst_req_drop", 32'(bus.start_req), 32'd0);
        chk("rst_press_cnt", 32'(bus.press_cnt), 32'd0);
        chk("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        steps(12, 1'b1, 1'b0);
        chk("rst_new_req", 32'(bus.start_req), 32'd1);
        chk("rst_new_press_cnt", 32'(bus.press_cnt), 32'd1);
        steps(10, 1'b0, 1'b0);
        steps(2, 1'b0, 1'b1);
        steps(2, 1'b0, 1'b0);

        // Unacknowledged request: times out after 8 cycles only with the feature.
        press_until_req(seen);
        chk("to_req_seen", 32'(seen), 32'd1);
        hi = 1; pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b1);
            if (bus.start_req === 1'b1) hi++;
            if (bus.timeout_p === 1'b1) pulses++;
        end
        chk("to_req_high_cycles", 32'(hi), TO_EN ? 32'd8 : 32'd13);
        chk("to_pulse_count", 32'(pulses), TO_EN ? 32'd1 : 32'd0);
        steps(2, 1'b0, 1'b1);
        steps(2, 1'b0, 1'b0);

        // busy_in on the timeout edge wins over the timeout.
        press_until_req(seen);
        chk("to_win_req_seen", 32'(seen), 32'd1);
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, 1'b1);
            if (bus.timeout_p === 1'b1) pulses++;
        end
        step(1'b0, 1'b1, 1'b1);
        if (bus.timeout_p === 1'b1) pulses++;
        chk("to_win_no_pulse", 32'(pulses), 32'd0);
        chk("to_win_req_low", 32'(bus.start_req), 32'd0);
        steps(2, 1'b0, 1'b1);
        steps(3, 1'b0, 1'b0);

        // Randomized runs of button/busy levels with occasional resets.
        for (int r = 0; r < 80; r++) begin
            rb   = 1'($urandom_range(0, 1));
            rbz  = 1'($urandom_range(0, 1));
            rr   = ($urandom_range(0, 39) != 0);
            rlen = $urandom_range(1, 10);
            for (int j = 0; j < rlen; j++) step(rb, rbz, (j == 0) ? rr : 1'b1);
        end

        // Drop counter saturation while busy stays high.
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 262; i++) begin
            steps(7, 1'b1, 1'b1);
            steps(7, 1'b0, 1'b1);
        end
        chk("drop_saturate", 32'(bus.drop_cnt), 32'd255);
        chk("sat_press_cnt", 32'(bus.press_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
